hbm_rd_arbiter: RTL and testbench

HBM_RD_ARBITER -- requirements
Module: hbm_rd_arbiter

---
 rtl/hbm_rd_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_hbm_rd_arbiter.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbm_rd_arbiter.sv
// hbm_rd_arbiter: round-robin arbiter that lets several core requesters share
// one HBM pseudo channel. The controller returns read data strictly in issue
// order, so a FIFO of requester tags steers each response back to its owner.
// A level-sensitive flush stops new grants, waits until every in-flight read
// has returned, and then pulses flush_done for one cycle.

`ifndef GROUP_CORE_NUM
`define GROUP_CORE_NUM 4
`endif
`ifndef HBM_AWIDTH
`define HBM_AWIDTH 32
`endif
`ifndef HBM_DWIDTH
`define HBM_DWIDTH 64
`endif

module hbm_rd_arbiter #(
  parameter int REQ_NUM         = `GROUP_CORE_NUM,
  parameter int HBM_AWIDTH      = `HBM_AWIDTH,
  parameter int HBM_DWIDTH      = `HBM_DWIDTH,
  parameter int MAX_OUTSTANDING = 16,
  localparam int TAG_W          = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
  localparam int PTR_W          = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REQ_NUM*HBM_AWIDTH-1:0] req_addr,
  input  logic [REQ_NUM-1:0]            req_valid,
  output logic [REQ_NUM-1:0]            req_ready,
  input  logic                          hbm_controller_full,
  output logic [HBM_AWIDTH-1:0]         rd_hbm_edge_addr,
  output logic                          rd_hbm_edge_valid,
  input  logic [HBM_DWIDTH-1:0]         hbm_controller_edge,
  input  logic                          hbm_controller_valid,
  output logic [HBM_DWIDTH-1:0]         resp_edge,
  output logic [REQ_NUM-1:0]            resp_valid,
  input  logic                          flush,
  output logic                          flush_done,
  output logic [CNT_W-1:0]              outstanding_cnt,
  output logic                          resp_err
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [TAG_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [TAG_W-1:0]        tag_mem [MAX_OUTSTANDING];

  logic [HBM_AWIDTH-1:0]   rd_addr_q;
  logic                    rd_valid_q;
  logic [HBM_DWIDTH-1:0]   resp_edge_q;
  logic [REQ_NUM-1:0]      resp_valid_q, resp_valid_d;
  logic                    resp_err_q;

  logic                    grant_en;
  logic                    grant_found;
  logic [TAG_W-1:0]        grant_idx;
  logic [TAG_W-1:0]        search_idx;
  int                      search_sum;
  logic                    push, pop;

  // Grants are only possible while running, not flushing, not back-pressured
  // and with room left for another in-flight tag; reset masks them outright.
  assign grant_en = rst && (state_q == ST_RUN) && !flush && !hbm_controller_full &&
                    (cnt_q < CNT_W'(MAX_OUTSTANDING));

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  // NOTE: combinational blocks use blocking '=' and give every output a
  // default first, so no latch is inferred on any path.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    search_idx  = '0;
    search_sum  = 0;
    for (int i = 0; i < REQ_NUM; i++) begin
      search_sum = (int'(rr_ptr_q) + i) % REQ_NUM;
      search_idx = TAG_W'(search_sum);
      if (!grant_found && req_valid[search_idx]) begin
        grant_found = 1'b1;
        grant_idx   = search_idx;
      end
    end
  end

  // One-hot ready, pointer advance, FIFO push/pop and occupancy update.
  always_comb begin
    req_ready = '0;
    push      = grant_en && grant_found;
    pop       = hbm_controller_valid && (cnt_q != '0);
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    if (push) begin
      req_ready[grant_idx] = 1'b1;
      rr_ptr_d = (grant_idx == TAG_W'(REQ_NUM - 1)) ? '0 : grant_idx + TAG_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Response routing: the oldest tag selects which requester sees the data.
  always_comb begin
    resp_valid_d = '0;
    if (pop) resp_valid_d[tag_mem[rd_ptr_q]] = 1'b1;
  end

  // Flush FSM: RUN -> DRAIN on flush, DRAIN -> DONE once nothing is in
  // flight, DONE pulses flush_done and always returns to RUN.
  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      ST_RUN:   if (flush) state_d = ST_DRAIN;
      ST_DRAIN: if ((cnt_q == '0) && !rd_valid_q) state_d = ST_DONE;
      ST_DONE: begin
        flush_done = 1'b1;
        state_d    = ST_RUN;
      end
      default:  state_d = ST_RUN;
    endcase
  end

  // Control state: FSM, arbitration pointer, tag FIFO pointers, occupancy.
  // NOTE: sequential blocks use non-blocking '<=' so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Tag storage written on every grant.
  // NOTE: the storage array has no reset; entries are only meaningful between
  // the FIFO pointers, and those pointers are reset.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_q] <= grant_idx;
  end

  // Registered controller request and routed response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr_q    <= '0;
      rd_valid_q   <= 1'b0;
      resp_edge_q  <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      rd_valid_q   <= push;
      resp_valid_q <= resp_valid_d;
      if (push) rd_addr_q <= req_addr[grant_idx*HBM_AWIDTH +: HBM_AWIDTH];
      if (pop)  resp_edge_q <= hbm_controller_edge;
      if (hbm_controller_valid && (cnt_q == '0)) resp_err_q <= 1'b1;
    end
  end

  assign rd_hbm_edge_addr  = rd_addr_q;
  assign rd_hbm_edge_valid = rd_valid_q;
  assign resp_edge         = resp_edge_q;
  assign resp_valid        = resp_valid_q;
  assign outstanding_cnt   = cnt_q;
  assign resp_err          = resp_err_q;

endmodule

// File: tb/tb_hbm_rd_arbiter.sv
// Testbench for hbm_rd_arbiter. A queue-based model of the arbiter (tag
// queue, round-robin pointer, flush state) predicts every output each cycle;
// scenario tasks add their own targeted comparisons on top.
`timescale 1ns/1ps

module tb_hbm_rd_arbiter;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int MAXO = 16;
  localparam int CW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic            full;
  logic [AW-1:0]   rd_addr;
  logic            rd_valid;
  logic [DW-1:0]   hdata;
  logic            hvalid;
  logic [DW-1:0]   resp_edge;
  logic [N-1:0]    resp_valid;
  logic            flush;
  logic            flush_done;
  logic [CW-1:0]   cnt;
  logic            resp_err;

  hbm_rd_arbiter #(
    .REQ_NUM(N), .HBM_AWIDTH(AW), .HBM_DWIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_valid(req_valid), .req_ready(req_ready),
    .hbm_controller_full(full),
    .rd_hbm_edge_addr(rd_addr), .rd_hbm_edge_valid(rd_valid),
    .hbm_controller_edge(hdata), .hbm_controller_valid(hvalid),
    .resp_edge(resp_edge), .resp_valid(resp_valid),
    .flush(flush), .flush_done(flush_done),
    .outstanding_cnt(cnt), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 = running, 1 = draining, 2 = done.
  int  m_state;
  int  m_rr;
  int  m_tags[$];
  bit  m_err;
  bit  m_rdv;
  int  cyc = 0;

  bit  last_xfer;
  int  last_grant;
  bit  last_pop;
  int  last_tag;

  function automatic void m_reset();
    m_state = 0;
    m_rr    = 0;
    m_tags.delete();
    m_err   = 1'b0;
    m_rdv   = 1'b0;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom};
  endfunction

  // Advance one clock with the inputs currently driven; the model predicts
  // the combinational ready before the edge and all registered outputs after.
  task automatic step();
    logic [N-1:0]  exp_ready;
    logic [N-1:0]  exp_rv;
    logic [N-1:0]  one;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    int g, k, t, pre;
    bit xfer, pop;
    one = 1;
    exp_ready = '0; exp_rv = '0; exp_addr = '0;
    g = -1; t = 0; xfer = 0; pop = 0;
    #1;
    if (m_state == 0 && !flush && !full && m_tags.size() < MAXO && req_valid != '0) begin
      for (int i = 0; i < N; i++) begin
        k = (m_rr + i) % N;
        if (g < 0 && req_valid[k]) g = k;
      end
      exp_ready = one << g;
      xfer = 1;
    end
    n_cmp++;
    if (req_ready !== exp_ready) begin
      n_bad++;
      $display("FAIL req_ready cyc=%0d: got %b expected %b", cyc, req_ready, exp_ready);
    end
    pre = m_tags.size();
    exp_data = hdata;
    if (hvalid) begin
      if (pre > 0) begin
        pop = 1;
        t = m_tags.pop_front();
        exp_rv = one << t;
      end else begin
        m_err = 1'b1;
      end
    end
    if (xfer) begin
      m_tags.push_back(g);
      m_rr = (g + 1) % N;
      exp_addr = req_addr[g*AW +: AW];
    end
    case (m_state)
      0: if (flush) m_state = 1;
      1: if (pre == 0 && !m_rdv) m_state = 2;
      default: m_state = 0;
    endcase
    m_rdv = xfer;
    @(posedge clk);
    #1;
    n_cmp++;
    if (rd_valid !== xfer) begin
      n_bad++;
      $display("FAIL rd_valid cyc=%0d: got %b expected %b", cyc, rd_valid, xfer);
    end
    if (xfer) begin
      n_cmp++;
      if (rd_addr !== exp_addr) begin
        n_bad++;
        $display("FAIL rd_addr cyc=%0d: got %h expected %h", cyc, rd_addr, exp_addr);
      end
    end
    n_cmp++;
    if (resp_valid !== exp_rv) begin
      n_bad++;
      $display("FAIL resp_valid cyc=%0d: got %b expected %b", cyc, resp_valid, exp_rv);
    end
    if (pop) begin
      n_cmp++;
      if (resp_edge !== exp_data) begin
        n_bad++;
        $display("FAIL resp_edge cyc=%0d: got %h expected %h", cyc, resp_edge, exp_data);
      end
    end
    n_cmp++;
    if (cnt !== CW'(m_tags.size())) begin
      n_bad++;
      $display("FAIL outstanding_cnt cyc=%0d: got %0d expected %0d", cyc, cnt, m_tags.size());
    end
    n_cmp++;
    if (flush_done !== (m_state == 2)) begin
      n_bad++;
      $display("FAIL flush_done cyc=%0d: got %b expected %b", cyc, flush_done, m_state == 2);
    end
    n_cmp++;
    if (resp_err !== m_err) begin
      n_bad++;
      $display("FAIL resp_err cyc=%0d: got %b expected %b", cyc, resp_err, m_err);
    end
    last_xfer  = xfer;
    last_grant = g;
    last_pop   = pop;
    last_tag   = t;
    cyc++;
  endtask

  // Return every outstanding read, then idle with flush low.
  task automatic drain();
    req_valid = '0; flush = 0; full = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_tags.size() == 0) break;
      hvalid = 1; hdata = rand_data();
      step();
    end
    hvalid = 0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 0; req_valid = '1; req_addr = '1; full = 0; hvalid = 0; hdata = '1; flush = 0;
    #12;
    n_cmp++;
    if ({req_ready, rd_valid, resp_valid, flush_done, cnt, resp_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected all 0",
               {req_ready, rd_valid, resp_valid, flush_done, cnt, resp_err});
    end
    n_cmp++;
    if ({rd_addr, resp_edge} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h/%h expected 0", rd_addr, resp_edge);
    end
    @(negedge clk);
    rst = 1; req_valid = '0;
    m_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int due[$];
    int grants[$];
    logic [N-1:0] resps[$];
    logic [N-1:0] exp_r;
    int c0;
    req_valid = '1;
    req_addr = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 40; c++) begin
      if (c >= 5) req_valid = '0;
      hvalid = (due.size() > 0 && due[0] == cyc);
      if (hvalid) void'(due.pop_front());
      hdata = rand_data();
      c0 = cyc;
      step();
      if (last_xfer) begin
        grants.push_back(last_grant);
        due.push_back(c0 + 3);
      end
      if (last_pop) resps.push_back(resp_valid);
      if (c >= 5 && due.size() == 0) break;
    end
    hvalid = 0;
    n_cmp++;
    if (grants.size() != 5 || resps.size() != 5) begin
      n_bad++;
      $display("FAIL rr_counts: got %0d grants %0d resps expected 5 5", grants.size(), resps.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (grants[i] != i % N) begin
          n_bad++;
          $display("FAIL rr_order[%0d]: got %0d expected %0d", i, grants[i], i % N);
        end
      end
      for (int i = 0; i < 4; i++) begin
        exp_r = '0; exp_r[i] = 1'b1;
        n_cmp++;
        if (resps[i] !== exp_r) begin
          n_bad++;
          $display("FAIL rr_resp[%0d]: got %b expected %b", i, resps[i], exp_r);
        end
      end
    end
    drain();
  endtask

  task automatic test_max_outstanding();
    int n_x;
    n_x = 0;
    req_addr = {$urandom, $urandom, $urandom, $urandom};
    req_addr[2*AW +: AW] = 32'h100;
    req_valid = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_xfer) n_x++;
    end
    n_cmp++;
    if (n_x != 16 || cnt !== 5'd16) begin
      n_bad++;
      $display("FAIL max_issue: got %0d issues cnt %0d expected 16 16", n_x, cnt);
    end
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL max_ready: got %b expected 0000", req_ready);
    end
    hvalid = 1; hdata = rand_data();
    step();
    hvalid = 0;
    n_cmp++;
    if (resp_valid !== 4'b0100 || cnt !== 5'd15) begin
      n_bad++;
      $display("FAIL max_pop: got %b cnt %0d expected 0100 cnt 15", resp_valid, cnt);
    end
    step();
    n_cmp++;
    if (!last_xfer || rd_addr !== 32'h100 || !rd_valid) begin
      n_bad++;
      $display("FAIL max_resume: got valid %b addr %h expected 1 00000100", rd_valid, rd_addr);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int held;
    req_valid = '1;
    req_addr = {$urandom, $urandom, $urandom, $urandom};
    step();
    held = (last_grant + 1) % N;
    full = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (rd_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_issue[%0d]: got %b expected 0", i, rd_valid);
      end
    end
    full = 0;
    step();
    n_cmp++;
    if (!last_xfer || !rd_valid || last_grant != held) begin
      n_bad++;
      $display("FAIL bp_resume: got valid %b expected grant %0d", rd_valid, held);
    end
    drain();
  endtask

  task automatic test_same_cycle();
    int first;
    logic [N-1:0] exp_r;
    req_valid = '1;
    req_addr = {$urandom, $urandom, $urandom, $urandom};
    step();
    first = last_grant;
    step();
    step();
    n_cmp++;
    if (cnt !== 5'd3) begin
      n_bad++;
      $display("FAIL same_pre: got cnt %0d expected 3", cnt);
    end
    hvalid = 1; hdata = rand_data();
    step();
    hvalid = 0;
    exp_r = '0; exp_r[first] = 1'b1;
    n_cmp++;
    if (cnt !== 5'd3 || resp_valid !== exp_r || !rd_valid) begin
      n_bad++;
      $display("FAIL same_cycle: got cnt %0d resp %b issue %b expected 3 %b 1",
               cnt, resp_valid, rd_valid, exp_r);
    end
    drain();
  endtask

  task automatic test_flush();
    int sent, pops, n_x, n_fd, r4, fd;
    sent = 0; pops = 0; n_x = 0; n_fd = 0; r4 = -100; fd = -1;
    req_valid = '1;
    req_addr = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) step();
    flush = 1;
    for (int k = 0; k < 40; k++) begin
      hvalid = (sent < 4) && (k % 3 == 0);
      if (hvalid) sent++;
      hdata = rand_data();
      step();
      if (last_xfer) n_x++;
      if (last_pop) begin
        pops++;
        if (pops == 4) r4 = cyc;
      end
      if (flush_done) begin
        n_fd++;
        fd = cyc;
        break;
      end
    end
    hvalid = 0;
    n_cmp++;
    if (n_x != 0 || n_fd != 1 || fd != r4 + 1) begin
      n_bad++;
      $display("FAIL flush_seq: got grants %0d pulses %0d at %0d expected 0 1 at %0d",
               n_x, n_fd, fd, r4 + 1);
    end
    flush = 0;
    step();
    step();
    n_cmp++;
    if (!last_xfer || !rd_valid) begin
      n_bad++;
      $display("FAIL flush_resume: got issue %b expected 1", rd_valid);
    end
    drain();
  endtask

  task automatic test_random();
    int n_x;
    n_x = 0;
    for (int i = 0; i < 1500; i++) begin
      req_valid = N'($urandom);
      req_addr  = {$urandom, $urandom, $urandom, $urandom};
      full      = ($urandom_range(0, 3) == 0);
      hvalid    = (m_tags.size() > 0) && ($urandom_range(0, 1) == 1);
      hdata     = rand_data();
      if ($urandom_range(0, 49) == 0) flush = ~flush;
      step();
      if (last_xfer) n_x++;
    end
    n_cmp++;
    if (n_x < 100) begin
      n_bad++;
      $display("FAIL random_activity: got %0d grants expected at least 100", n_x);
    end
    drain();
  endtask

  task automatic test_resp_err();
    hvalid = 1; hdata = rand_data();
    step();
    hvalid = 0;
    n_cmp++;
    if (resp_valid !== '0 || resp_err !== 1'b1 || cnt !== '0) begin
      n_bad++;
      $display("FAIL resp_err_case: got resp %b err %b cnt %0d expected 0000 1 0",
               resp_valid, resp_err, cnt);
    end
    step();
  endtask

  task automatic test_async_reset();
    req_valid = '1;
    req_addr = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      hvalid = (m_tags.size() > 0) && ($urandom_range(0, 1) == 1);
      hdata = rand_data();
      step();
    end
    hvalid = 0;
    #2;
    rst = 0;
    #1;
    n_cmp++;
    if ({req_ready, rd_valid, resp_valid, flush_done, cnt, resp_err} !== '0 ||
        {rd_addr, resp_edge} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got %b expected all 0",
               {req_ready, rd_valid, resp_valid, flush_done, cnt, resp_err});
    end
    @(negedge clk);
    rst = 1; req_valid = '0;
    m_reset();
    @(posedge clk); #1;
    hvalid = 1; hdata = rand_data();
    step();
    hvalid = 0;
    n_cmp++;
    if (resp_valid !== '0 || resp_err !== 1'b1 || cnt !== '0) begin
      n_bad++;
      $display("FAIL post_reset_resp: got resp %b err %b cnt %0d expected 0000 1 0",
               resp_valid, resp_err, cnt);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_max_outstanding();
    test_backpressure();
    test_same_cycle();
    test_flush();
    test_random();
    test_resp_err();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
